// File: rtl/stack_arbiter_if.sv
// Client-side handshake bundle for stack_arbiter.
//   req[1:0]      per-requester request, held until acknowledged
//   op[1:0]       per-requester operation (1 = push, 0 = pop)
//   wdata0/1      push data for requester 0 / requester 1
//   ack[1:0]      one-cycle acknowledge to the granted requester
//   rsp_data      popped value, valid while ack is high
//   rsp_err       operation rejected (overflow/underflow), valid with ack
interface stack_arbiter_if #(
  parameter int DW = 32
);
  logic [1:0]    req;
  logic [1:0]    op;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    ack;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport master (output req, op, wdata0, wdata1, input ack, rsp_data, rsp_err);
  modport slave  (input req, op, wdata0, wdata1, output ack, rsp_data, rsp_err);
endinterface

// File: rtl/stack_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a LIFO stack memory.
// Issues one single-cycle stack operation per grant, rejects overflow and
// underflow before they reach the stack, and returns popped data with a
// one-cycle acknowledge.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cli             client handshake (req/op/wdata in, ack/rsp_data/rsp_err out)
//   busy            high whenever the FSM is not IDLE
//   ovf_sticky      set by a rejected push, cleared only by rst
//   unf_sticky      set by a rejected pop, cleared only by rst
//   stk_enable/push/pop, stk_data_in   stack strobes and push data
//   stk_data_out, stk_sp, stk_empty    stack top, occupancy, empty flag
//
// state | meaning
// IDLE  | waiting for a request; arbitration and grant latch
// ISSUE | legality check, single-cycle stack strobe
// RESP  | ack pulse to the granted requester, round-robin update
module stack_arbiter #(
  parameter int DEPTH = 64,
  parameter int DW    = 32
) (
  input  logic           clk,
  input  logic           rst,
  stack_arbiter_if.slave cli,
  output logic           busy,
  output logic           ovf_sticky,
  output logic           unf_sticky,
  output logic           stk_enable,
  output logic           stk_push,
  output logic           stk_pop,
  output logic [DW-1:0]  stk_data_in,
  input  logic [DW-1:0]  stk_data_out,
  input  logic [31:0]    stk_sp,
  input  logic           stk_empty
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          rr_q;
  logic          g_q;
  logic          op_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_err_q;
  logic          win;
  logic          legal;
  logic [1:0]    ack;

  // A lone requester wins outright; on contention the rr pointer decides.
  assign win   = (cli.req == 2'b11) ? rr_q : cli.req[1];
  assign legal = op_q ? (stk_sp != 32'(DEPTH)) : !stk_empty;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|cli.req) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and ack are gated by rst so a reset landing in ISSUE or RESP
  // never reaches the stack or the requester.
  always_comb begin
    ack         = 2'b00;
    stk_enable  = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = '0;
    busy        = (state_q != IDLE);
    case (state_q)
      ISSUE: begin
        stk_data_in = data_q;
        if (legal && !rst) begin
          stk_enable = 1'b1;
          stk_push   = op_q;
          stk_pop    = !op_q;
        end
      end
      RESP: begin
        if (!rst) ack[g_q] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= 1'b0;
      g_q        <= 1'b0;
      op_q       <= 1'b0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|cli.req) begin
            g_q    <= win;
            op_q   <= cli.op[win];
            data_q <= win ? cli.wdata1 : cli.wdata0;
          end
        end
        ISSUE: begin
          if (legal) begin
            rsp_err_q <= 1'b0;
            // stk_data_out is still the pre-pop top at this edge
            if (!op_q) rsp_data_q <= stk_data_out;
          end else begin
            rsp_err_q <= 1'b1;
            if (op_q) begin
              ovf_sticky <= 1'b1;
            end else begin
              unf_sticky <= 1'b1;
              rsp_data_q <= '0;
            end
          end
        end
        RESP: rr_q <= ~g_q;
        default: ;
      endcase
    end
  end

  assign cli.ack      = ack;
  assign cli.rsp_data = rsp_data_q;
  assign cli.rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;
  localparam int DEPTH = 64;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_arbiter_if #(.DW(DW)) cli ();

  logic          busy, ovf_sticky, unf_sticky;
  logic          stk_enable, stk_push, stk_pop;
  logic [DW-1:0] stk_data_in, stk_data_out;
  logic [31:0]   stk_sp;
  logic          stk_empty;

  stack_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cli          (cli),
    .busy         (busy),
    .ovf_sticky   (ovf_sticky),
    .unf_sticky   (unf_sticky),
    .stk_enable   (stk_enable),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_sp       (stk_sp),
    .stk_empty    (stk_empty)
  );

  // behavioural stack memory driven by the DUT strobes
  logic [DW-1:0] mem [DEPTH];
  int unsigned   sp;
  always @(posedge clk) begin
    if (rst) sp <= 0;
    else if (stk_enable && stk_push && sp < DEPTH) begin
      mem[sp] <= stk_data_in;
      sp      <= sp + 1;
    end else if (stk_enable && stk_pop && sp > 0) sp <= sp - 1;
  end
  assign stk_sp       = sp;
  assign stk_empty    = (sp == 0);
  assign stk_data_out = (sp == 0) ? '0 : mem[sp-1];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]    ack;
    logic          is_pop;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_stk[$];
  logic        rr_exp = 1'b0;
  int          push_cnt = 0, pop_cnt = 0;
  int          exp_push = 0, exp_pop = 0;

  task automatic predict(input logic id, input logic op, input logic [DW-1:0] d);
    exp_t e;
    e.ack    = (id ? 2'b10 : 2'b01);
    e.is_pop = !op;
    e.data   = '0;
    e.err    = 1'b0;
    if (op) begin
      if (ref_stk.size() == DEPTH) e.err = 1'b1;
      else begin ref_stk.push_back(d); exp_push++; end
    end else begin
      if (ref_stk.size() == 0) e.err = 1'b1;
      else begin e.data = ref_stk.pop_back(); exp_pop++; end
    end
    sb.push_back(e);
    rr_exp = !id;
  endtask

  // response monitor / scoreboard consumer
  always @(negedge clk) begin
    if (stk_push && stk_pop) chk("push_and_pop", 1, 0);
    if (stk_enable && stk_push) push_cnt++;
    if (stk_enable && stk_pop)  pop_cnt++;
    if (cli.ack != 2'b00) begin
      if (sb.size() == 0) chk("unexpected_ack", {62'd0, cli.ack}, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_id", {62'd0, cli.ack}, {62'd0, e.ack});
        chk("rsp_err", {63'd0, cli.rsp_err}, {63'd0, e.err});
        if (e.is_pop) chk("rsp_data", {32'd0, cli.rsp_data}, {32'd0, e.data});
      end
    end
  end

  task automatic do_op(input logic id, input logic op, input logic [DW-1:0] d);
    int n;
    predict(id, op, d);
    @(negedge clk);
    cli.op[id] = op;
    if (id) cli.wdata1 = d; else cli.wdata0 = d;
    cli.req[id] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_issue", {63'd0, busy}, 1);
    end while (!cli.ack[id] && n < 10);
    if (!cli.ack[id]) chk("ack_timeout", 0, 1);
    cli.req[id] = 1'b0;
    chk("latency", n, 2);
  endtask

  // both requesters hold req with the same op until each has n/2 acks
  task automatic do_dual(input logic op, input int n, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int rem0, rem1, r0, r1, t;
    logic w;
    r0 = n / 2; r1 = n / 2;
    for (int k = 0; k < n; k++) begin
      w = (r0 > 0 && r1 > 0) ? rr_exp : (r0 > 0 ? 1'b0 : 1'b1);
      predict(w, op, w ? d1 : d0);
      if (w) r1--; else r0--;
    end
    rem0 = n / 2; rem1 = n / 2;
    @(negedge clk);
    cli.op = {op, op}; cli.wdata0 = d0; cli.wdata1 = d1;
    cli.req = 2'b11;
    t = 0;
    while ((rem0 > 0 || rem1 > 0) && t < 20 * n) begin
      @(negedge clk);
      t++;
      if (cli.ack[0]) begin rem0--; if (rem0 == 0) cli.req[0] = 1'b0; end
      if (cli.ack[1]) begin rem1--; if (rem1 == 0) cli.req[1] = 1'b0; end
    end
    if (rem0 > 0 || rem1 > 0) chk("dual_timeout", 0, 1);
    cli.req = 2'b00;
  endtask

  task automatic chk_strobes(input string tag);
    chk({tag, "_pushes"}, push_cnt, exp_push);
    chk({tag, "_pops"}, pop_cnt, exp_pop);
    chk({tag, "_sp"}, stk_sp, ref_stk.size());
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int t;
    cli.req = 2'b00; cli.op = 2'b00; cli.wdata0 = '0; cli.wdata1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 0);
    chk("rst_ack", {62'd0, cli.ack}, 0);
    chk("rst_rsp_data", {32'd0, cli.rsp_data}, 0);
    chk("rst_rsp_err", {63'd0, cli.rsp_err}, 0);
    chk("rst_stickies", {62'd0, ovf_sticky, unf_sticky}, 0);
    chk("rst_strobes", {61'd0, stk_enable, stk_push, stk_pop}, 0);

    // single push then pop
    do_op(1'b0, 1'b1, 32'hDEADBEEF);
    do_op(1'b1, 1'b0, 32'h0);
    chk_strobes("single");

    // simultaneous pushes then pops, then sustained alternation
    do_dual(1'b1, 2, 32'hAAAA0001, 32'hBBBB0002);
    do_dual(1'b0, 2, 32'h0, 32'h0);
    do_dual(1'b1, 4, 32'hC0C0C0C0, 32'hD0D0D0D0);
    do_dual(1'b0, 4, 32'h0, 32'h0);
    chk_strobes("dual");

    // underflow
    do_op(1'b1, 1'b0, 32'h0);
    chk("unf_sticky", {63'd0, unf_sticky}, 1);
    chk("unf_no_ovf", {63'd0, ovf_sticky}, 0);
    chk_strobes("underflow");

    // overflow
    for (int i = 0; i < DEPTH; i++) do_op(1'b0, 1'b1, 32'(i));
    chk("full_sp", stk_sp, 64);
    do_op(1'b0, 1'b1, 32'd64);
    chk("ovf_sticky", {63'd0, ovf_sticky}, 1);
    do_op(1'b1, 1'b0, 32'h0);
    chk_strobes("overflow");

    // reset during ISSUE of a push
    @(negedge clk);
    cli.op[0] = 1'b1; cli.wdata0 = 32'h12345678; cli.req[0] = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstmid_strobe", {62'd0, stk_enable, stk_push}, 0);
    chk("rstmid_ack", {62'd0, cli.ack}, 0);
    cli.req = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    ref_stk.delete();
    rr_exp = 1'b0;
    chk("rstmid_busy", {63'd0, busy}, 0);
    chk("rstmid_ack2", {62'd0, cli.ack}, 0);
    chk("rstmid_stickies", {62'd0, ovf_sticky, unf_sticky}, 0);
    chk_strobes("rstmid");
    do_op(1'b1, 1'b1, 32'hFEEDF00D);
    do_op(1'b0, 1'b0, 32'h0);
    chk_strobes("after_rst");

    // held req: two separate transactions
    predict(1'b0, 1'b1, 32'h55AA55AA);
    predict(1'b0, 1'b1, 32'h55AA55AA);
    @(negedge clk);
    cli.op[0] = 1'b1; cli.wdata0 = 32'h55AA55AA; cli.req[0] = 1'b1;
    t = 0;
    for (int a = 0; a < 2; a++) begin
      do begin @(negedge clk); t++; end while (!cli.ack[0] && t < 20);
    end
    if (!cli.ack[0]) chk("held_timeout", 0, 1);
    cli.req = 2'b00;
    repeat (3) @(negedge clk);
    chk_strobes("held");
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
